iddr_gearbox: RTL and testbench

- Parametrised successor to the generic input DDR capture flop.
- Captures a WIDTH-bit bus on both clock edges and retimes both samples into the rising-edge domain (q1/q2).
- Adds run-time SDR/DDR mode select, edge-pair swap, and a symbol gearbox that packs 2*RATIO symbols into one wide word with a valid strobe and bitslip alignment.
- Sits between the PHY-side pads and the MAC receive datapath.

---
 rtl/iddr_gearbox.sv | 141 ++++++++++++++
 tb/tb_iddr_gearbox.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iddr_gearbox.sv
// Double-edge input capture with retiming into the rising-edge domain, followed by a
// symbol gearbox that packs 2*RATIO symbols per output word with bitslip alignment.
module iddr_gearbox #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned RATIO = 2,
  localparam int unsigned S    = 2 * RATIO,
  localparam int unsigned CW   = (S > 1) ? $clog2(S) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     d,
  input  logic                 ddr_en,
  input  logic                 swap,
  input  logic                 bitslip,
  output logic [WIDTH-1:0]     q1,
  output logic [WIDTH-1:0]     q2,
  output logic [S*WIDTH-1:0]   out_data,
  output logic                 out_valid,
  output logic [CW-1:0]        slip_count
);

  logic [WIDTH-1:0]   r_q, f_q, f_hold_q;
  logic [WIDTH-1:0]   q1_q, q1_d, q2_q, q2_d;
  logic               ddr_q, swap_q;
  // Two-stage qualifier: q holds real samples only from the second edge after reset.
  logic               r_vld_q, q_vld_q;
  logic [S*WIDTH-1:0] asm_q, asm_d;
  logic [CW-1:0]      c_q, c_d;
  logic [S*WIDTH-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [CW-1:0]      slip_q, slip_d;
  logic               mode_chg;
  logic [WIDTH-1:0]   sym;
  logic               take;

  // Falling-edge capture of d.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q <= '0;
    end else begin
      f_q <= d;
    end
  end

  // Rising-edge capture, falling-sample hold and mode copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q      <= '0;
      f_hold_q <= '0;
      ddr_q    <= 1'b0;
      swap_q   <= 1'b0;
      r_vld_q  <= 1'b0;
      q_vld_q  <= 1'b0;
    end else begin
      r_q      <= d;
      f_hold_q <= f_q;
      ddr_q    <= ddr_en;
      swap_q   <= swap;
      r_vld_q  <= 1'b1;
      q_vld_q  <= r_vld_q;
    end
  end

  // Retimed symbol pair selection.
  always_comb begin
    q1_d = r_q;
    q2_d = '0;
    if (ddr_en) begin
      if (swap) begin
        q1_d = f_hold_q;
        q2_d = r_q;
      end else begin
        q2_d = f_q;
      end
    end
  end

  // Any change of ddr_en/swap invalidates the symbols now in the q stage.
  assign mode_chg = (ddr_en != ddr_q) || (swap != swap_q);

  // Gearbox: write accepted symbols into slot c, emit word when slot S-1 fills.
  // ddr_q is the mode the q stage was loaded under, so it decides whether q2 counts.
  always_comb begin
    asm_d       = asm_q;
    c_d         = c_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    slip_d      = slip_q;
    sym         = '0;
    take        = 1'b0;
    if (mode_chg) begin
      c_d = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sym  = (i == 0) ? q1_q : q2_q;
        take = q_vld_q && ((i == 0) ? !bitslip : ddr_q);
        if (take) begin
          asm_d[int'(c_d) * WIDTH +: WIDTH] = sym;
          if (c_d == CW'(S - 1)) begin
            out_data_d  = asm_d;
            out_valid_d = 1'b1;
            c_d         = '0;
          end else begin
            c_d = c_d + CW'(1);
          end
        end
      end
      if (bitslip) begin
        slip_d = (slip_q == CW'(S - 1)) ? '0 : slip_q + CW'(1);
      end
    end
  end

  // Retime and gearbox state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q        <= '0;
      q2_q        <= '0;
      asm_q       <= '0;
      c_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      slip_q      <= '0;
    end else begin
      q1_q        <= q1_d;
      q2_q        <= q2_d;
      asm_q       <= asm_d;
      c_q         <= c_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      slip_q      <= slip_d;
    end
  end

  assign q1         = q1_q;
  assign q2         = q2_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign slip_count = slip_q;

endmodule

// File: tb/tb_iddr_gearbox.sv
// Bench for iddr_gearbox (WIDTH=4, RATIO=2): directed stimulus, an edge-indexed sample
// history model checked every cycle, plus hand-computed literal expectations.
module tb_iddr_gearbox;
  localparam int W = 4;
  localparam int R = 2;
  localparam int S = 2 * R;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] d = '0;
  logic         ddr_en = 1'b0;
  logic         swap = 1'b0;
  logic         bitslip = 1'b0;
  logic [W-1:0] q1, q2;
  logic [15:0]  out_data;
  logic         out_valid;
  logic [1:0]   slip_count;

  int errors = 0;
  int checks = 0;

  iddr_gearbox #(.WIDTH(W), .RATIO(R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d          (d),
    .ddr_en     (ddr_en),
    .swap       (swap),
    .bitslip    (bitslip),
    .q1         (q1),
    .q2         (q2),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .slip_count (slip_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // ra[k] = R[k], fa[k+1] = F[k] (fa[0] = falling sample before edge 0, or 0).
  logic [W-1:0] ra [0:1023];
  logic [W-1:0] fa [0:1024];
  int           ecnt = 0;
  logic [W-1:0] eq1 = '0, eq2 = '0;
  logic         pm_ddr = 1'b0, pm_sw = 1'b0;
  logic [W-1:0] partial [$];
  logic [15:0]  edata = '0;
  logic         evalid = 1'b0;
  int           eslip = 0;

  task automatic push(input logic [W-1:0] s);
    partial.push_back(s);
    if (partial.size() == S) begin
      edata = '0;
      for (int i = 0; i < S; i++) edata[i*W +: W] = partial[i];
      evalid = 1'b1;
      partial.delete();
    end
  endtask

  task automatic model_edge();
    int e, k;
    if (!rst_n) begin
      ecnt = 0; fa[0] = '0; partial.delete();
      eq1 = '0; eq2 = '0; edata = '0; evalid = 1'b0; eslip = 0;
      pm_ddr = 1'b0; pm_sw = 1'b0;
      return;
    end
    e = ecnt;
    ra[e] = d;
    evalid = 1'b0;
    if ((ddr_en != pm_ddr) || (swap != pm_sw)) begin
      partial.delete();
    end else begin
      if (e >= 2) begin
        if (!bitslip) push(eq1);
        if (pm_ddr) push(eq2);
      end
      if (bitslip) eslip = (eslip + 1) % S;
    end
    if (e >= 1) begin
      k = e - 1;
      if (!ddr_en) begin eq1 = ra[k]; eq2 = '0; end
      else if (!swap) begin eq1 = ra[k]; eq2 = fa[k+1]; end
      else begin eq1 = fa[k]; eq2 = ra[k]; end
    end
    pm_ddr = ddr_en;
    pm_sw = swap;
    ecnt++;
  endtask

  // Compare process: model updates at each rising edge, outputs checked 2 time units later.
  initial begin
    forever begin
      @(posedge clk);
      model_edge();
      #2;
      if (!rst_n) begin
        check("rst_q1", 32'(q1), 0);
        check("rst_q2", 32'(q2), 0);
      end else if (ecnt >= 2) begin
        check("q1", 32'(q1), 32'(eq1));
        check("q2", 32'(q2), 32'(eq2));
      end
      check("out_valid", 32'(out_valid), 32'(evalid));
      check("out_data", 32'(out_data), 32'(edata));
      check("slip_count", 32'(slip_count), 32'(eslip));
      @(negedge clk);
      if (!rst_n) fa[0] = '0;
      else if (ecnt <= 1024) fa[ecnt] = d;
    end
  end

  // ---------------- stimulus ----------------
  // One clock: rv sampled on the rising edge, fv on the following falling edge.
  task automatic step(input logic [3:0] rv, input logic [3:0] fv, input logic de,
                      input logic sw, input logic bs);
    d = rv; ddr_en = de; swap = sw; bitslip = bs;
    @(posedge clk);
    #1 d = fv;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ddr_en = 1'b0; swap = 1'b0; bitslip = 1'b0; d = '0;
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [3:0] nib(input int x);
    return 4'(((x - 1) % 15) + 1);
  endfunction

  initial begin
    // DDR, swap=0
    do_reset();
    step(4'h1, 4'h2, 1, 0, 0);
    step(4'h3, 4'h4, 1, 0, 0);
    step(4'h5, 4'h6, 1, 0, 0);
    check("ddr_novalid_e2", 32'(out_valid), 0);
    step(4'h7, 4'h8, 1, 0, 0);
    check("ddr_q1_e3", 32'(q1), 32'h5);
    check("ddr_q2_e3", 32'(q2), 32'h6);
    check("ddr_word0", 32'(out_data), 32'h4321);
    check("ddr_valid0", 32'(out_valid), 1);
    step(4'h0, 4'h0, 1, 0, 0);
    check("ddr_gap", 32'(out_valid), 0);
    step(4'h0, 4'h0, 1, 0, 0);
    check("ddr_word1", 32'(out_data), 32'h8765);
    check("ddr_valid1", 32'(out_valid), 1);

    // Reset mid-stream
    do_reset();
    step(4'h1, 4'h2, 1, 0, 0);
    step(4'h3, 4'h4, 1, 0, 0);
    step(4'h5, 4'h6, 1, 0, 0);
    step(4'h7, 4'h8, 1, 0, 0);
    check("pre_rst_word", 32'(out_data), 32'h4321);
    rst_n = 1'b0;
    #1;
    check("async_rst_q1", 32'(q1), 0);
    check("async_rst_q2", 32'(q2), 0);
    check("async_rst_data", 32'(out_data), 0);
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_slip", 32'(slip_count), 0);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(4'h9, 4'hA, 1, 0, 0);
    step(4'hB, 4'hC, 1, 0, 0);
    step(4'hD, 4'hE, 1, 0, 0);
    check("post_rst_novalid", 32'(out_valid), 0);
    step(4'hF, 4'h1, 1, 0, 0);
    check("post_rst_word", 32'(out_data), 32'hCBA9);
    check("post_rst_valid", 32'(out_valid), 1);

    // SDR
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step((i < 8) ? 4'(i + 1) : 4'h0, 4'hF, 0, 0, 0);
      check("sdr_q2_zero", 32'(q2), 0);
      if (i == 5) begin
        check("sdr_word0", 32'(out_data), 32'h4321);
        check("sdr_valid0", 32'(out_valid), 1);
      end
      if (i == 7) check("sdr_gap", 32'(out_valid), 0);
      if (i == 9) begin
        check("sdr_word1", 32'(out_data), 32'h8765);
        check("sdr_valid1", 32'(out_valid), 1);
      end
    end

    // Bitslip, DDR
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(nib(2 * i + 1), nib(2 * i + 2), 1, 0, (i == 4) || (i >= 9 && i <= 11));
      if (i == 3) check("slip_word0", 32'(out_data), 32'h4321);
      if (i == 4) check("slip_count1", 32'(slip_count), 1);
      if (i == 6) begin
        check("slip_word1", 32'(out_data), 32'h9876);
        check("slip_valid1", 32'(out_valid), 1);
      end
      if (i == 11) check("slip_wrap", 32'(slip_count), 0);
    end

    // Swap
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(4'(2 * i + 1), 4'(2 * i + 2), 1, (i >= 2), 0);
      if (i == 2) begin
        check("swap_q1_e2", 32'(q1), 32'h2);
        check("swap_q2_e2", 32'(q2), 32'h3);
      end
      if (i == 3) begin
        check("swap_q1_e3", 32'(q1), 32'h4);
        check("swap_q2_e3", 32'(q2), 32'h5);
      end
      if (i == 4) begin
        check("swap_word", 32'(out_data), 32'h5432);
        check("swap_valid", 32'(out_valid), 1);
      end
    end

    // Mode change mid-word, bitslip on the change cycle ignored
    do_reset();
    step(4'h1, 4'h2, 1, 0, 0);
    step(4'h3, 4'h4, 1, 0, 1);
    step(4'h5, 4'h6, 1, 0, 0);
    step(4'h7, 4'h8, 0, 0, 1);
    check("chg_slip_kept", 32'(slip_count), 1);
    for (int i = 0; i < 4; i++) begin
      check("chg_novalid", 32'(out_valid), 0);
      step(4'(9 + 2 * i), 4'h0, 0, 0, 0);
    end
    check("chg_word", 32'(out_data), 32'hB975);
    check("chg_valid", 32'(out_valid), 1);
    check("chg_slip_final", 32'(slip_count), 1);
    step(4'h0, 4'h0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
